// File: rtl/sysmon_minmax_store.sv
// Per-channel sample store tracking current, min, max and exponential average.
// All state lives in flops; one write and one registered read per cycle.
module sysmon_minmax_store #(
    parameter int unsigned CHANNEL_COUNT = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SIGNED_DATA   = 0,
    parameter int unsigned AVG_SHIFT     = 4,
    parameter int unsigned CH_WIDTH      = $clog2(CHANNEL_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [CH_WIDTH-1:0]   wchan,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  clr,
    input  logic [CH_WIDTH+1:0]   raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam int unsigned AccWidth = DATA_WIDTH + AVG_SHIFT;

    logic [DATA_WIDTH-1:0] cur_q [CHANNEL_COUNT];
    logic [DATA_WIDTH-1:0] min_q [CHANNEL_COUNT];
    logic [DATA_WIDTH-1:0] max_q [CHANNEL_COUNT];
    logic [AccWidth-1:0]   acc_q [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] valid_q;

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q;

    logic [DATA_WIDTH-1:0] w_min, w_max, min_d, max_d;
    logic [AccWidth-1:0]   w_acc, acc_shr, wdata_ext, acc_d;
    logic                  first_sample, wr_lt, wr_gt;

    logic [CH_WIDTH-1:0]   rd_ch;
    logic [1:0]            rd_field;

    // Next values for the channel being written, computed once and steered by wchan.
    always_comb begin
        w_min        = min_q[wchan];
        w_max        = max_q[wchan];
        w_acc        = acc_q[wchan];
        first_sample = clr | ~valid_q[wchan];
        if (SIGNED_DATA != 0) begin
            wdata_ext = AccWidth'($signed(wdata));
            acc_shr   = AccWidth'($signed(w_acc) >>> AVG_SHIFT);
            wr_lt     = $signed(wdata) < $signed(w_min);
            wr_gt     = $signed(wdata) > $signed(w_max);
        end else begin
            wdata_ext = AccWidth'(wdata);
            acc_shr   = w_acc >> AVG_SHIFT;
            wr_lt     = wdata < w_min;
            wr_gt     = wdata > w_max;
        end
        min_d = (first_sample || wr_lt) ? wdata : w_min;
        max_d = (first_sample || wr_gt) ? wdata : w_max;
        acc_d = first_sample ? (wdata_ext << AVG_SHIFT) : (w_acc - acc_shr + wdata_ext);
    end

    assign rd_ch    = raddr[CH_WIDTH+1:2];
    assign rd_field = raddr[1:0];

    always_comb begin
        rdata_d = '0;
        unique case (rd_field)
            2'd0: rdata_d = cur_q[rd_ch];
            2'd1: rdata_d = min_q[rd_ch];
            2'd2: rdata_d = max_q[rd_ch];
            2'd3: rdata_d = acc_q[rd_ch][AVG_SHIFT +: DATA_WIDTH];
        endcase
    end

    // Read path samples pre-write state, so a same-cycle write is seen one read later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q    <= '{default: '0};
            min_q    <= '{default: '0};
            max_q    <= '{default: '0};
            acc_q    <= '{default: '0};
            valid_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= valid_q[rd_ch];
            if (clr) begin
                valid_q <= '0;
            end
            if (wen) begin
                cur_q[wchan]   <= wdata;
                min_q[wchan]   <= min_d;
                max_q[wchan]   <= max_d;
                acc_q[wchan]   <= acc_d;
                valid_q[wchan] <= 1'b1;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sysmon_minmax_store.sv
// Directed bench for sysmon_minmax_store: unsigned and signed instances share stimulus.
module tb_sysmon_minmax_store;

    logic        clk;
    logic        reset;
    logic        wen;
    logic [3:0]  wchan;
    logic [15:0] wdata;
    logic        clr;
    logic [5:0]  raddr;
    logic [15:0] rdata_u, rdata_s;
    logic        rvalid_u, rvalid_s;

    int n_vec;
    int n_err;

    sysmon_minmax_store #(
        .CHANNEL_COUNT(16), .DATA_WIDTH(16), .SIGNED_DATA(0), .AVG_SHIFT(4)
    ) u_dut (
        .clk(clk), .reset(reset), .wen(wen), .wchan(wchan), .wdata(wdata),
        .clr(clr), .raddr(raddr), .rdata(rdata_u), .rvalid(rvalid_u)
    );

    sysmon_minmax_store #(
        .CHANNEL_COUNT(16), .DATA_WIDTH(16), .SIGNED_DATA(1), .AVG_SHIFT(4)
    ) u_dut_s (
        .clk(clk), .reset(reset), .wen(wen), .wchan(wchan), .wdata(wdata),
        .clr(clr), .raddr(raddr), .rdata(rdata_s), .rvalid(rvalid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b1;
        wen   = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [15:0] d);
        wen   = 1'b1;
        wchan = ch;
        wdata = d;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ch, input logic [1:0] f);
        raddr = {ch, f};
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({rvalid_u, rdata_u} !== 17'h0) begin
            $display("FAIL reset_out: got %h expected 0", {rvalid_u, rdata_u});
            n_err++;
        end
        for (int a = 0; a < 64; a++) begin
            raddr = 6'(a);
            @(negedge clk);
            n_vec++;
            if ({rvalid_u, rdata_u} !== 17'h0) begin
                $display("FAIL reset_read[%0d]: got %h expected 0", a, {rvalid_u, rdata_u});
                n_err++;
            end
        end
    endtask

    task automatic test_minmax();
        logic [16:0] exp_v [4];
        exp_v[0] = {1'b1, 16'd200};
        exp_v[1] = {1'b1, 16'd50};
        exp_v[2] = {1'b1, 16'd200};
        exp_v[3] = {1'b1, 16'd103};
        wr(4'd3, 16'd100);
        wr(4'd3, 16'd50);
        wr(4'd3, 16'd200);
        for (int f = 0; f < 4; f++) begin
            rd(4'd3, 2'(f));
            n_vec++;
            if ({rvalid_u, rdata_u} !== exp_v[f]) begin
                $display("FAIL ch3_field%0d: got %h expected %h", f, {rvalid_u, rdata_u}, exp_v[f]);
                n_err++;
            end
        end
        rd(4'd2, 2'd0);
        n_vec++;
        if (rvalid_u !== 1'b0) begin
            $display("FAIL ch2_rvalid: got %b expected 0", rvalid_u);
            n_err++;
        end
    endtask

    task automatic test_signed();
        logic [15:0] exp_u [3];
        logic [15:0] exp_s [3];
        exp_u[0] = 16'h0001; exp_u[1] = 16'hFFFF; exp_u[2] = 16'hEFFF;
        exp_s[0] = 16'hFFFF; exp_s[1] = 16'h0001; exp_s[2] = 16'hFFFF;
        do_reset();
        wr(4'd0, 16'hFFFF);
        wr(4'd0, 16'h0001);
        for (int f = 1; f < 4; f++) begin
            rd(4'd0, 2'(f));
            n_vec++;
            if (rdata_u !== exp_u[f-1]) begin
                $display("FAIL unsigned_field%0d: got %h expected %h", f, rdata_u, exp_u[f-1]);
                n_err++;
            end
            n_vec++;
            if (rdata_s !== exp_s[f-1]) begin
                $display("FAIL signed_field%0d: got %h expected %h", f, rdata_s, exp_s[f-1]);
                n_err++;
            end
        end
    endtask

    task automatic test_average();
        logic [19:0] acc;
        do_reset();
        wr(4'd5, 16'd0);
        acc = 20'd0;
        rd(4'd5, 2'd3);
        n_vec++;
        if (rdata_u !== 16'd0) begin
            $display("FAIL avg_first: got %0d expected 0", rdata_u);
            n_err++;
        end
        for (int k = 0; k < 16; k++) begin
            wr(4'd5, 16'd1600);
            acc = acc - (acc >> 4) + 20'd1600;
            rd(4'd5, 2'd3);
            n_vec++;
            if (rdata_u !== acc[19:4]) begin
                $display("FAIL avg_step%0d: got %0d expected %0d", k, rdata_u, acc[19:4]);
                n_err++;
            end
            n_vec++;
            if (rdata_s !== acc[19:4]) begin
                $display("FAIL avg_step%0d_s: got %0d expected %0d", k, rdata_s, acc[19:4]);
                n_err++;
            end
        end
        n_vec++;
        if (!(rdata_u < 16'd1600)) begin
            $display("FAIL avg_below_input: got %0d expected < 1600", rdata_u);
            n_err++;
        end
    endtask

    task automatic test_clear();
        do_reset();
        wr(4'd1, 16'd10);
        wr(4'd1, 16'd90);
        wr(4'd4, 16'd7);
        clr   = 1'b1;
        wen   = 1'b1;
        wchan = 4'd1;
        wdata = 16'd40;
        @(negedge clk);
        clr = 1'b0;
        wen = 1'b0;
        for (int f = 0; f < 4; f++) begin
            rd(4'd1, 2'(f));
            n_vec++;
            if ({rvalid_u, rdata_u} !== {1'b1, 16'd40}) begin
                $display("FAIL clr_ch1_field%0d: got %h expected %h", f, {rvalid_u, rdata_u},
                         {1'b1, 16'd40});
                n_err++;
            end
        end
        rd(4'd4, 2'd0);
        n_vec++;
        if ({rvalid_u, rdata_u} !== {1'b0, 16'd7}) begin
            $display("FAIL clr_ch4_kept: got %h expected %h", {rvalid_u, rdata_u}, {1'b0, 16'd7});
            n_err++;
        end
        for (int c = 0; c < 16; c++) begin
            if (c != 1) begin
                rd(4'(c), 2'd0);
                n_vec++;
                if (rvalid_u !== 1'b0) begin
                    $display("FAIL clr_rvalid_ch%0d: got %b expected 0", c, rvalid_u);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        wr(4'd7, 16'd5);
        wen   = 1'b1;
        wchan = 4'd7;
        wdata = 16'd9;
        raddr = {4'd7, 2'd0};
        @(negedge clk);
        wen = 1'b0;
        n_vec++;
        if ({rvalid_u, rdata_u} !== {1'b1, 16'd5}) begin
            $display("FAIL collide_old: got %h expected %h", {rvalid_u, rdata_u}, {1'b1, 16'd5});
            n_err++;
        end
        rd(4'd7, 2'd0);
        n_vec++;
        if ({rvalid_u, rdata_u} !== {1'b1, 16'd9}) begin
            $display("FAIL collide_new: got %h expected %h", {rvalid_u, rdata_u}, {1'b1, 16'd9});
            n_err++;
        end
        reset = 1'b1;
        wen   = 1'b1;
        wchan = 4'd7;
        wdata = 16'd11;
        raddr = {4'd7, 2'd0};
        @(negedge clk);
        reset = 1'b0;
        wen   = 1'b0;
        n_vec++;
        if ({rvalid_u, rdata_u} !== 17'h0) begin
            $display("FAIL midreset_out: got %h expected 0", {rvalid_u, rdata_u});
            n_err++;
        end
        rd(4'd7, 2'd0);
        n_vec++;
        if ({rvalid_u, rdata_u} !== 17'h0) begin
            $display("FAIL midreset_read: got %h expected 0", {rvalid_u, rdata_u});
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        wen   = 1'b0;
        wchan = '0;
        wdata = '0;
        clr   = 1'b0;
        raddr = '0;
        test_reset();
        test_minmax();
        test_signed();
        test_average();
        test_clear();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
